traffic_light_fsm: RTL and testbench
====================================

// Module: traffic_light_fsm
// PURPOSE
//   Junction phase controller fed directly by sensor_interface. Consumes the
//   vehicle_detected (side road) and ped_detected strobes, latches them as
//   pending requests, and sequences main/side vehicle lamps and the pedestrian
//   walk lamp through timed phases. Main road rests on green. Its outputs
//   drive the lamp drivers.
// PARAMETERS
//   MAIN_MIN_GREEN  10  minimum main-green dwell, clock cycles (>=1)
//   SIDE_GREEN       8  side-green dwell, cycles (>=1)
//   YELLOW           3  yellow dwell, both roads, cycles (>=1)
//   ALL_RED          2  all-red clearance dwell, cycles (>=1)
//   WALK             6  pedestrian walk dwell, cycles (>=1)
//   CNT_W            8  phase timer width; must hold max(param)-1
// PORTS
//   clk               in   1  system clock, rising edge
//   reset             in   1  asynchronous, active-low reset
//   vehicle_detected  in   1  side-road vehicle present (level or 1-cycle pulse)
//   ped_detected      in   1  pedestrian request (level or 1-cycle pulse)
//   main_light        out  3  {red,yellow,green}, main road, one-hot
//   side_light        out  3  {red,yellow,green}, side road, one-hot
//   walk              out  1  pedestrian walk lamp
//   veh_pending       out  1  latched side-road request
//   ped_pending       out  1  latched pedestrian request
//   phase             out  3  current state encoding (debug/verification)
// BEHAVIOUR
//   States (phase code): 0 MAIN_G, 1 MAIN_Y, 2 RED_IN, 3 SIDE_G, 4 SIDE_Y,
//     5 PED_WALK, 6 RED_OUT. Codes 7 or any illegal value go to MAIN_G next edge.
//   Timer: on every state entry, cnt loads (dwell-1), then decrements each edge.
//     A timed state lasts exactly its dwell in cycles and exits on the edge after cnt==0.
//   MAIN_G: holds at cnt==0 until veh_pending|ped_pending, then goes to MAIN_Y.
//     A request that is already pending at expiry gives exactly MAIN_MIN_GREEN cycles.
//   MAIN_Y (YELLOW) -> RED_IN (ALL_RED).
//   RED_IN exit: ped_pending -> PED_WALK (pedestrian has priority); else
//     veh_pending -> SIDE_G; else MAIN_G.
//   SIDE_G (SIDE_GREEN) -> SIDE_Y (YELLOW) -> RED_OUT (ALL_RED) -> MAIN_G.
//   PED_WALK (WALK) -> RED_OUT -> MAIN_G. One request is served per cycle through MAIN_G.
//     A request left outstanding is served after the next MAIN_MIN_GREEN.
//   Requests: the pending bit sets on any cycle its input is 1.
//     veh_pending clears on the SIDE_G entry edge; ped_pending clears on the PED_WALK entry edge.
//     On the entry edge, clear wins over a simultaneous input.
//     While the phase being served is active, input is still latched (re-request).
//   Lamps (Moore decode of the state register, no input dependence):
//     MAIN_G: main=001, side=100. MAIN_Y: main=010, side=100.
//     SIDE_G: main=100, side=001. SIDE_Y: main=100, side=010.
//     RED_IN/RED_OUT/PED_WALK: main=100, side=100.
//     walk=1 only in PED_WALK. Main and side are never both non-red.
//   Reset (async, any time incl. mid-phase): phase=MAIN_G, cnt=MAIN_MIN_GREEN-1,
//     main=001, side=100, walk=0, veh_pending=0, ped_pending=0.
//     The first edge after release counts as MAIN_G cycle 1.
// TESTING
//   1 Idle: no requests for 50 cycles -> phase stays 0, main=001, side=100, walk=0.
//   2 Vehicle pulse at cycle 2 -> MAIN_G 10 cycles, MAIN_Y 3, RED_IN 2, SIDE_G 8,
//     SIDE_Y 3, RED_OUT 2, then MAIN_G. veh_pending drops on SIDE_G entry.
//   3 Ped pulse at cycle 20 after reset -> MAIN_Y on the next edge, then RED_IN 2,
//     PED_WALK 6 with walk=1 and both roads red, then RED_OUT 2, then MAIN_G.
//   4 Vehicle and ped asserted on the same cycle -> PED_WALK first. veh_pending stays 1.
//     SIDE_G follows after a full 10-cycle MAIN_G.
//   5 Vehicle held high through SIDE_G -> veh_pending re-sets. A second side phase
//     runs after the next 10-cycle MAIN_G.
//   6 reset driven low mid-SIDE_G, and phase forced to 7 -> immediate reset values.
//     Forced code 7 returns to MAIN_G in one edge. Check one-hot lamps every cycle.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// Junction phase controller: latches side-road and pedestrian requests and
// sequences main/side vehicle lamps and the walk lamp through timed phases.
module traffic_light_fsm #(
    parameter int MAIN_MIN_GREEN = 10,
    parameter int SIDE_GREEN     = 8,
    parameter int YELLOW         = 3,
    parameter int ALL_RED        = 2,
    parameter int WALK           = 6,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vehicle_detected,
    input  logic       ped_detected,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       veh_pending,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [2:0] S_MAIN_G   = 3'd0;
    localparam logic [2:0] S_MAIN_Y   = 3'd1;
    localparam logic [2:0] S_RED_IN   = 3'd2;
    localparam logic [2:0] S_SIDE_G   = 3'd3;
    localparam logic [2:0] S_SIDE_Y   = 3'd4;
    localparam logic [2:0] S_PED_WALK = 3'd5;
    localparam logic [2:0] S_RED_OUT  = 3'd6;

    localparam logic [CNT_W-1:0] L_MAIN_G = CNT_W'(MAIN_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_SIDE_G = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(WALK - 1);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_veh_pend;
    logic             r_ped_pend;

    logic [2:0]       w_next;
    logic             w_cnt_zero;
    logic             w_enter;
    logic [CNT_W-1:0] w_load;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_MAIN_G:   if (w_cnt_zero && (r_veh_pend || r_ped_pend)) w_next = S_MAIN_Y;
            S_MAIN_Y:   if (w_cnt_zero) w_next = S_RED_IN;
            S_RED_IN: begin
                // pedestrian request outranks a waiting side-road vehicle
                if (w_cnt_zero) begin
                    if (r_ped_pend)      w_next = S_PED_WALK;
                    else if (r_veh_pend) w_next = S_SIDE_G;
                    else                 w_next = S_MAIN_G;
                end
            end
            S_SIDE_G:   if (w_cnt_zero) w_next = S_SIDE_Y;
            S_SIDE_Y:   if (w_cnt_zero) w_next = S_RED_OUT;
            S_PED_WALK: if (w_cnt_zero) w_next = S_RED_OUT;
            S_RED_OUT:  if (w_cnt_zero) w_next = S_MAIN_G;
            default:    w_next = S_MAIN_G;
        endcase
    end

    // No state re-enters itself, so any change of code is a phase entry.
    assign w_enter = (w_next != r_state);

    always_comb begin
        w_load = L_MAIN_G;
        case (w_next)
            S_MAIN_Y, S_SIDE_Y:   w_load = L_YELLOW;
            S_RED_IN, S_RED_OUT:  w_load = L_ALLRED;
            S_SIDE_G:             w_load = L_SIDE_G;
            S_PED_WALK:           w_load = L_WALK;
            default:              w_load = L_MAIN_G;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_MAIN_G;
            r_cnt   <= L_MAIN_G;
        end else begin
            r_state <= w_next;
            if (w_enter)
                r_cnt <= w_load;
            else if (!w_cnt_zero)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    // Serving a request clears it on the entry edge, even if the input is still high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_veh_pend <= 1'b0;
            r_ped_pend <= 1'b0;
        end else begin
            if (w_enter && (w_next == S_SIDE_G))
                r_veh_pend <= 1'b0;
            else if (vehicle_detected)
                r_veh_pend <= 1'b1;

            if (w_enter && (w_next == S_PED_WALK))
                r_ped_pend <= 1'b0;
            else if (ped_detected)
                r_ped_pend <= 1'b1;
        end
    end

    always_comb begin
        main_light = LAMP_R;
        side_light = LAMP_R;
        walk       = 1'b0;
        case (r_state)
            S_MAIN_G:   main_light = LAMP_G;
            S_MAIN_Y:   main_light = LAMP_Y;
            S_SIDE_G:   side_light = LAMP_G;
            S_SIDE_Y:   side_light = LAMP_Y;
            S_PED_WALK: walk       = 1'b1;
            default:    ;
        endcase
    end

    assign veh_pending = r_veh_pend;
    assign ped_pending = r_ped_pend;
    assign phase       = r_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: table of per-cycle segments with
// hand-computed phase/pending values, plus reset and illegal-code sequences.
module tb_traffic_light_fsm;

    logic       clk;
    logic       reset;
    logic       vehicle_detected;
    logic       ped_detected;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       veh_pending;
    logic       ped_pending;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    traffic_light_fsm dut (
        .clk              (clk),
        .reset            (reset),
        .vehicle_detected (vehicle_detected),
        .ped_detected     (ped_detected),
        .main_light       (main_light),
        .side_light       (side_light),
        .walk             (walk),
        .veh_pending      (veh_pending),
        .ped_pending      (ped_pending),
        .phase            (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         veh;
        bit         ped;
        int         reps;
        logic [2:0] ph;
        bit         vp;
        bit         pp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit veh, input bit ped, input int reps,
                       input logic [2:0] ph, input bit vp, input bit pp);
        vec_t v;
        v.rst = rst; v.veh = veh; v.ped = ped; v.reps = reps;
        v.ph = ph; v.vp = vp; v.pp = pp;
        tbl.push_back(v);
    endtask

    // {main, side, walk} required for each phase code
    function automatic logic [6:0] lamps(input logic [2:0] p);
        case (p)
            3'd0:    return 7'b001_100_0;
            3'd1:    return 7'b010_100_0;
            3'd3:    return 7'b100_001_0;
            3'd4:    return 7'b100_010_0;
            3'd5:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [2:0] ph, input bit vp, input bit pp);
        check(name, {phase, main_light, side_light, walk, veh_pending, ped_pending},
              {ph, lamps(ph), vp, pp});
        check({name, "_safe"},
              {$onehot(main_light), $onehot(side_light), !(main_light != 3'b100 && side_light != 3'b100)},
              3'b111);
    endtask

    task automatic do_reset();
        @(negedge clk);
        vehicle_detected = 1'b0;
        ped_detected     = 1'b0;
        reset            = 1'b0;
        #1 check_outputs("reset_state", 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive inputs (already at a negedge), clock once, sample after the edge.
    task automatic step(input bit veh, input bit ped, input string name,
                        input logic [2:0] ph, input bit vp, input bit pp);
        vehicle_detected = veh;
        ped_detected     = ped;
        @(posedge clk);
        #1 check_outputs(name, ph, vp, pp);
        @(negedge clk);
    endtask

    initial begin
        reset            = 1'b0;
        vehicle_detected = 1'b0;
        ped_detected     = 1'b0;

        // 1: idle
        add(1, 0, 0, 50, 3'd0, 0, 0);
        // 2: vehicle pulse in cycle 2
        add(1, 0, 0, 1, 3'd0, 0, 0);
        add(0, 1, 0, 1, 3'd0, 1, 0);
        add(0, 0, 0, 7, 3'd0, 1, 0);
        add(0, 0, 0, 3, 3'd1, 1, 0);
        add(0, 0, 0, 2, 3'd2, 1, 0);
        add(0, 0, 0, 8, 3'd3, 0, 0);
        add(0, 0, 0, 3, 3'd4, 0, 0);
        add(0, 0, 0, 2, 3'd6, 0, 0);
        add(0, 0, 0, 5, 3'd0, 0, 0);
        // 3: pedestrian pulse in cycle 20, main green long expired
        add(1, 0, 0, 19, 3'd0, 0, 0);
        add(0, 0, 1, 1, 3'd0, 0, 1);
        add(0, 0, 0, 3, 3'd1, 0, 1);
        add(0, 0, 0, 2, 3'd2, 0, 1);
        add(0, 0, 0, 6, 3'd5, 0, 0);
        add(0, 0, 0, 2, 3'd6, 0, 0);
        add(0, 0, 0, 3, 3'd0, 0, 0);
        // 4: both requests together, pedestrian first, vehicle after full green
        add(1, 1, 1, 1, 3'd0, 1, 1);
        add(0, 0, 0, 8, 3'd0, 1, 1);
        add(0, 0, 0, 3, 3'd1, 1, 1);
        add(0, 0, 0, 2, 3'd2, 1, 1);
        add(0, 0, 0, 6, 3'd5, 1, 0);
        add(0, 0, 0, 2, 3'd6, 1, 0);
        add(0, 0, 0, 10, 3'd0, 1, 0);
        add(0, 0, 0, 3, 3'd1, 1, 0);
        add(0, 0, 0, 2, 3'd2, 1, 0);
        add(0, 0, 0, 8, 3'd3, 0, 0);
        add(0, 0, 0, 3, 3'd4, 0, 0);
        add(0, 0, 0, 2, 3'd6, 0, 0);
        add(0, 0, 0, 2, 3'd0, 0, 0);
        // 5: vehicle held through side green: clear wins on entry, then re-sets
        add(1, 1, 0, 9, 3'd0, 1, 0);
        add(0, 1, 0, 3, 3'd1, 1, 0);
        add(0, 1, 0, 2, 3'd2, 1, 0);
        add(0, 1, 0, 1, 3'd3, 0, 0);
        add(0, 1, 0, 7, 3'd3, 1, 0);
        add(0, 0, 0, 3, 3'd4, 1, 0);
        add(0, 0, 0, 2, 3'd6, 1, 0);
        add(0, 0, 0, 10, 3'd0, 1, 0);
        add(0, 0, 0, 3, 3'd1, 1, 0);
        add(0, 0, 0, 2, 3'd2, 1, 0);
        add(0, 0, 0, 8, 3'd3, 0, 0);
        add(0, 0, 0, 3, 3'd4, 0, 0);
        add(0, 0, 0, 2, 3'd6, 0, 0);
        add(0, 0, 0, 3, 3'd0, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            for (int r = 0; r < tbl[i].reps; r++)
                step(tbl[i].veh, tbl[i].ped, $sformatf("row%0d_cyc%0d", i, r),
                     tbl[i].ph, tbl[i].vp, tbl[i].pp);
        end

        // 6a: asynchronous reset in the middle of side green
        do_reset();
        step(1, 0, "mid_req", 3'd0, 1, 0);
        for (int r = 0; r < 15; r++) begin
            vehicle_detected = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        #1 check_outputs("mid_side_g", 3'd3, 0, 0);
        reset = 1'b0;
        #1 check_outputs("async_reset", 3'd0, 0, 0);
        @(posedge clk);
        #1 check_outputs("reset_hold", 3'd0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 12; r++)
            step(0, 0, $sformatf("post_reset_%0d", r), 3'd0, 0, 0);

        // 6b: illegal code 7 goes back to main green in one edge
        force dut.r_state = 3'd7;
        #1 check_outputs("forced_7", 3'd7, 0, 0);
        release dut.r_state;
        @(posedge clk);
        #1 check_outputs("recover_7", 3'd0, 0, 0);
        @(negedge clk);
        step(0, 0, "recover_hold", 3'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
